// File: rtl/cordic_angle_reduce_if.sv
// Handshake and data bundle between the angle reducer and its neighbours:
// the upstream angle source on the input side and the CORDIC rotator on the
// output side.
interface cordic_angle_reduce_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] theta_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_start;
  logic [WIDTH-1:0] y_start;
  logic [WIDTH-1:0] theta;
  logic             neg;

  // Upstream source and downstream sink, as seen together from the bench
  modport master (
    output in_valid, theta_in, out_ready,
    input  in_ready, out_valid, x_start, y_start, theta, neg
  );

  // The reducer itself
  modport slave (
    input  in_valid, theta_in, out_ready,
    output in_ready, out_valid, x_start, y_start, theta, neg
  );
endinterface

// File: rtl/cordic_angle_reduce.sv
// Angle reduction ahead of the CORDIC rotator. Any signed Q4.28 angle is first
// wrapped into [-pi, pi) by whole turns, then folded by pi into [-pi/2, pi/2].
// When a fold happens, neg tells the post-stage to negate cos and sin.
// The constants below assume WIDTH=32 with 28 fractional bits.
module cordic_angle_reduce #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_angle_reduce_if.slave bus
);

  localparam logic signed [WIDTH-1:0] TWO_PI  = 32'sh6487ED51;
  localparam logic signed [WIDTH-1:0] PI      = 32'sh3243F6A9;
  localparam logic signed [WIDTH-1:0] HALF_PI = 32'sh1921FB54;
  localparam logic signed [WIDTH-1:0] X_INIT  = 32'sh10000000;

  typedef enum logic [1:0] {
    IDLE,
    WRAP,
    FOLD,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic signed [WIDTH-1:0] z;
  logic signed [WIDTH-1:0] theta_q;
  logic [WIDTH-1:0]        x_start_q;
  logic [WIDTH-1:0]        y_start_q;
  logic                    neg_q;
  logic                    out_valid_q;
  logic                    wrap_high;
  logic                    wrap_low;

  assign wrap_high = (z >= PI);
  assign wrap_low  = (z < -PI);

  // State register; reset abandons any angle still being reduced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; input side is only open while idle
  always_comb begin
    next_state   = state;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = WRAP;
      end
      WRAP: begin
        if (!wrap_high && !wrap_low) next_state = FOLD;
      end
      FOLD: begin
        next_state = DONE;
      end
      DONE: begin
        if (bus.out_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Working angle: captured on accept, then pulled into [-pi, pi) by full turns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      z <= bus.theta_in;
    end else if (state == WRAP) begin
      if (wrap_high) begin
        z <= z - TWO_PI;
      end else if (wrap_low) begin
        z <= z + TWO_PI;
      end
    end
  end

  // Result registers: loaded by the fold step, held until the rotator takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      theta_q     <= '0;
      neg_q       <= 1'b0;
      x_start_q   <= '0;
      y_start_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (state == FOLD) begin
      if (z > HALF_PI) begin
        theta_q <= z - PI;
        neg_q   <= 1'b1;
      end else if (z < -HALF_PI) begin
        theta_q <= z + PI;
        neg_q   <= 1'b1;
      end else begin
        theta_q <= z;
        neg_q   <= 1'b0;
      end
      x_start_q   <= X_INIT;
      y_start_q   <= '0;
      out_valid_q <= 1'b1;
    end else if (state == DONE && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.theta     = theta_q;
  assign bus.neg       = neg_q;
  assign bus.x_start   = x_start_q;
  assign bus.y_start   = y_start_q;
  assign bus.out_valid = out_valid_q;

endmodule
